// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - multi-cycle digit-serial full subtractor with valid/ready handshakes
//
// Purpose:
//   Computes d = m - n - bin on WIDTH-bit operands, DIGIT bits per clock.
//   The borrow ripples between cycles through an internal register.
//   Also reports the unsigned borrow-out and the signed overflow.
//
// Ports:
//   clk        in   1      clock, rising edge
//   reset      in   1      synchronous, active-high reset
//   in_valid   in   1      operands m, n, bin valid
//   in_ready   out  1      operands can be accepted (IDLE only)
//   m          in   WIDTH  minuend
//   n          in   WIDTH  subtrahend
//   bin        in   1      borrow-in
//   out_valid  out  1      d, bout, ovf valid (DONE only)
//   out_ready  in   1      consumer accepts result
//   d          out  WIDTH  difference, m - n - bin mod 2^WIDTH
//   bout       out  1      unsigned borrow-out
//   ovf        out  1      two's-complement overflow
module serial_subtractor #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] m,
   input  logic [WIDTH-1:0] n,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] d,
   output logic             bout,
   output logic             ovf
);

   localparam int STEPS = WIDTH / DIGIT;
   localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t state;
   state_t state_next;

   logic [WIDTH-1:0] m_sr;
   logic [WIDTH-1:0] n_sr;
   logic             borrow;
   logic [CW-1:0]    count;
   logic             m_msb;
   logic             n_msb;

   logic             accept;
   logic             last_step;
   logic [DIGIT:0]   step;
   logic [WIDTH+DIGIT-1:0] d_cat;
   logic [WIDTH-1:0] d_next;

   assign accept    = in_valid && in_ready;
   assign last_step = (state == RUN) && (count == LAST);

   // Zero-extending to DIGIT+1 bits leaves the borrow of this digit in the top bit.
   assign step   = {1'b0, m_sr[DIGIT-1:0]} - {1'b0, n_sr[DIGIT-1:0]} - {{DIGIT{1'b0}}, borrow};
   // New digit enters at the MSB end; after STEPS shifts the first digit sits at the LSB.
   assign d_cat  = {step[DIGIT-1:0], d};
   assign d_next = d_cat[WIDTH+DIGIT-1:DIGIT];

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = !reset;
            if (accept) state_next = RUN;
         end
         RUN: begin
            if (count == LAST) state_next = DONE;
         end
         DONE: begin
            out_valid = !reset;
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         m_sr   <= '0;
         n_sr   <= '0;
         borrow <= 1'b0;
         count  <= '0;
         m_msb  <= 1'b0;
         n_msb  <= 1'b0;
         d      <= '0;
         bout   <= 1'b0;
         ovf    <= 1'b0;
      end else if (accept) begin
         m_sr   <= m;
         n_sr   <= n;
         borrow <= bin;
         count  <= '0;
         m_msb  <= m[WIDTH-1];
         n_msb  <= n[WIDTH-1];
      end else if (state == RUN) begin
         m_sr   <= m_sr >> DIGIT;
         n_sr   <= n_sr >> DIGIT;
         borrow <= step[DIGIT];
         count  <= count + 1'b1;
         d      <= d_next;
         if (last_step) begin
            bout <= step[DIGIT];
            // Operands of differing sign whose result sign differs from the minuend overflowed.
            ovf  <= (m_msb != n_msb) && (d_next[WIDTH-1] != m_msb);
         end
      end
   end

endmodule
